// File: rtl/ec_core_pkg.sv
// rtl/ec_core_pkg.sv - shared codes, state encoding and microword type for the Y-sequencer
package ec_core_pkg;

  localparam logic [2:0] Y_SET_Y     = 3'd0;
  localparam logic [2:0] Y_SET_S     = 3'd1;
  localparam logic [2:0] Y_SET_2     = 3'd2;
  localparam logic [2:0] Y_SET_A     = 3'd3;
  localparam logic [2:0] Y_SET_T     = 3'd4;
  localparam logic [2:0] Y_SET_CZ    = 3'd5;
  localparam logic [2:0] Y_SET_ECP1X = 3'd6;
  localparam logic [2:0] Y_SET_ECP1Y = 3'd7;

  localparam logic [1:0] CMD_CLR  = 2'd0;
  localparam logic [1:0] CMD_DBL  = 2'd1;
  localparam logic [1:0] CMD_ADD  = 2'd2;
  localparam logic [1:0] CMD_LOAD = 2'd3;

  localparam logic [1:0] MA_MUL = 2'd0;
  localparam logic [1:0] MA_ADD = 2'd1;
  localparam logic [1:0] MA_SUB = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [2:0] yop;
    logic [1:0] maop;
    logic       last;
  } microword_t;

  function automatic microword_t mw(input logic [2:0] yop, input logic [1:0] maop,
                                    input logic last);
    microword_t w;
    w.yop  = yop;
    w.maop = maop;
    w.last = last;
    return w;
  endfunction

endpackage

// File: rtl/ec_core_yseq_if.sv
// rtl/ec_core_yseq_if.sv - command, Y-register and modular-arithmetic handshake bundle
interface ec_core_yseq_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       abort;
  logic [2:0] y_op;
  logic       y_en;
  logic       y_clr;
  logic       ma_start;
  logic [1:0] ma_op;
  logic       ma_done;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] step_idx;

  modport master (
    output cmd_valid, cmd_op, abort, ma_done,
    input  cmd_ready, y_op, y_en, y_clr, ma_start, ma_op, busy, done, err, step_idx
  );

  modport slave (
    input  cmd_valid, cmd_op, abort, ma_done,
    output cmd_ready, y_op, y_en, y_clr, ma_start, ma_op, busy, done, err, step_idx
  );
endinterface

// File: rtl/ec_core_yseq_rom.sv
// rtl/ec_core_yseq_rom.sv - microcode table mapping (command, step) to a microword
module ec_core_yseq_rom
  import ec_core_pkg::*;
(
  input  logic [1:0] cmd_i,
  input  logic [1:0] step_i,
  output microword_t word_o
);

  always_comb begin
    word_o = mw(Y_SET_Y, MA_MUL, 1'b1);
    case ({cmd_i, step_i})
      {CMD_DBL, 2'd0}:  word_o = mw(Y_SET_2,     MA_MUL, 1'b0);
      {CMD_DBL, 2'd1}:  word_o = mw(Y_SET_A,     MA_ADD, 1'b0);
      {CMD_DBL, 2'd2}:  word_o = mw(Y_SET_CZ,    MA_MUL, 1'b0);
      {CMD_DBL, 2'd3}:  word_o = mw(Y_SET_T,     MA_SUB, 1'b1);
      {CMD_ADD, 2'd0}:  word_o = mw(Y_SET_ECP1X, MA_SUB, 1'b0);
      {CMD_ADD, 2'd1}:  word_o = mw(Y_SET_ECP1Y, MA_SUB, 1'b0);
      {CMD_ADD, 2'd2}:  word_o = mw(Y_SET_CZ,    MA_MUL, 1'b1);
      {CMD_LOAD, 2'd0}: word_o = mw(Y_SET_Y,     MA_MUL, 1'b0);
      {CMD_LOAD, 2'd1}: word_o = mw(Y_SET_S,     MA_MUL, 1'b1);
      default:          word_o = mw(Y_SET_Y,     MA_MUL, 1'b1);
    endcase
  end

endmodule

// File: rtl/ec_core_yseq.sv
// rtl/ec_core_yseq.sv - micro-sequencer driving Y-register loads and modular-arithmetic steps
module ec_core_yseq
  import ec_core_pkg::*;
#(
  parameter int TIMEOUT_W = 10
) (
  input logic           clk,
  input logic           rst,
  ec_core_yseq_if.slave bus
);

  localparam logic [TIMEOUT_W-1:0] CNT_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               state_q;
  logic [1:0]           cmd_q;
  logic [1:0]           step_q;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 last_q;
  logic [2:0]           y_op_q;
  logic                 y_en_q;
  logic                 y_clr_q;
  logic                 ma_start_q;
  logic [1:0]           ma_op_q;
  logic                 done_q;
  logic                 err_q;
  logic                 busy_q;

  logic [1:0]           rom_cmd_d;
  logic [1:0]           rom_step_d;
  microword_t           rom_word;

  // Outputs are registered, so the ROM is addressed with the step about to be entered.
  always_comb begin
    rom_cmd_d  = cmd_q;
    rom_step_d = step_q;
    if (state_q == ST_IDLE) begin
      rom_cmd_d  = bus.cmd_op;
      rom_step_d = 2'd0;
    end else if (state_q == ST_WAIT) begin
      rom_step_d = step_q + 2'd1;
    end
  end

  ec_core_yseq_rom u_rom (
    .cmd_i  (rom_cmd_d),
    .step_i (rom_step_d),
    .word_o (rom_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CMD_CLR;
      step_q     <= 2'd0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      y_op_q     <= 3'd0;
      y_en_q     <= 1'b0;
      y_clr_q    <= 1'b0;
      ma_start_q <= 1'b0;
      ma_op_q    <= 2'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      y_en_q     <= 1'b0;
      y_clr_q    <= 1'b0;
      ma_start_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      if (state_q != ST_IDLE && bus.abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.cmd_valid) begin
              cmd_q  <= bus.cmd_op;
              step_q <= 2'd0;
              busy_q <= 1'b1;
              if (bus.cmd_op == CMD_CLR) begin
                state_q <= ST_CLR;
                y_clr_q <= 1'b1;
              end else begin
                state_q <= ST_LOAD;
                y_en_q  <= 1'b1;
                y_op_q  <= rom_word.yop;
              end
            end
          end
          ST_CLR: begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
          ST_LOAD: begin
            state_q    <= ST_START;
            ma_start_q <= 1'b1;
            ma_op_q    <= rom_word.maop;
            last_q     <= rom_word.last;
            cnt_q      <= '0;
          end
          ST_START: state_q <= ST_WAIT;
          ST_WAIT: begin
            if (bus.ma_done) begin
              if (last_q) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_LOAD;
                step_q  <= step_q + 2'd1;
                y_en_q  <= 1'b1;
                y_op_q  <= rom_word.yop;
              end
            end else if (cnt_q == CNT_LAST) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.y_op      = y_op_q;
  assign bus.y_en      = y_en_q;
  assign bus.y_clr     = y_clr_q;
  assign bus.ma_start  = ma_start_q;
  assign bus.ma_op     = ma_op_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.step_idx  = step_q;

endmodule

// File: tb/tb_ec_core_yseq.sv
// tb/tb_ec_core_yseq.sv - randomized self-checking bench for the Y-sequencer
module tb_ec_core_yseq;
  import ec_core_pkg::*;

  localparam int TMO_CYCLES = (1 << 4) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ec_core_yseq_if bus ();

  ec_core_yseq #(.TIMEOUT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int model_yop = 0;

  int yop_tab [4][4] = '{'{0, 0, 0, 0}, '{2, 3, 5, 4}, '{6, 7, 5, 0}, '{0, 1, 0, 0}};
  int maop_tab[4][4] = '{'{0, 0, 0, 0}, '{0, 1, 0, 2}, '{2, 2, 0, 0}, '{0, 0, 0, 0}};
  int nsteps  [4]    = '{0, 4, 3, 2};

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // lat: cycles from ma_start to ma_done (<0 = never); abort_step: step whose ma_done carries abort.
  task automatic exec(input logic [1:0] op, input int lat, input int abort_step,
                      input bit noise, input bit idle_abort);
    int n_y, n_ma, n_clr, clr_cyc, done_at, done_cyc, done_err, n, step_len;
    bit aborted, fin;
    n_y = 0; n_ma = 0; n_clr = 0; clr_cyc = -1; done_at = -1; done_cyc = -1; done_err = -1;
    aborted = 0; fin = 0; n = nsteps[op]; step_len = 2 + lat;
    check_eq("ready_before", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.abort = idle_abort;
    @(negedge clk);
    bus.cmd_valid = 1'b0; bus.abort = 1'b0;
    for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
      bus.ma_done = 1'b0; bus.abort = 1'b0;
      if (aborted) begin
        check_eq("abort_strobes", {bus.y_en, bus.y_clr, bus.ma_start, bus.done}, 0);
        check_eq("abort_idle", {bus.busy, bus.cmd_ready}, 1);
        fin = 1;
      end else begin
        if (bus.y_en) begin
          check_eq("y_en_excl", {bus.y_clr, bus.ma_start}, 0);
          check_eq("load_step", bus.step_idx, n_y);
          check_eq("y_op_seq", bus.y_op, (n_y < 4) ? yop_tab[op][n_y] : -1);
          if (n_y < 4) model_yop = yop_tab[op][n_y];
          n_y++;
        end else begin
          check_eq("y_op_hold", bus.y_op, model_yop);
        end
        if (bus.y_clr) begin
          check_eq("y_clr_excl", {bus.y_en, bus.ma_start}, 0);
          n_clr++; clr_cyc = cyc;
        end
        if (bus.ma_start) begin
          check_eq("ma_op_seq", bus.ma_op, (n_ma < 4) ? maop_tab[op][n_ma] : -1);
          check_eq("start_step", bus.step_idx, n_ma);
          n_ma++;
          if (lat >= 0) done_at = cyc + lat;
        end
        if (bus.done) begin
          done_cyc = cyc; done_err = bus.err; fin = 1;
        end else if (cyc == done_at) begin
          bus.ma_done = 1'b1;
          if (n_ma - 1 == abort_step) begin
            bus.abort = 1'b1; aborted = 1;
          end
        end else if (noise && lat >= 0 && op != CMD_CLR && ((cyc - 1) % step_len) < 2) begin
          bus.ma_done = 1'b1;
        end
      end
      if (!fin) @(negedge clk);
    end
    check_eq("bounded", fin, 1);
    bus.ma_done = 1'b0; bus.abort = 1'b0;
    if (aborted) begin
      check_eq("abort_loads", n_y, abort_step + 1);
      check_eq("abort_starts", n_ma, abort_step + 1);
      check_eq("abort_no_done", done_cyc, -1);
    end else begin
      if (op == CMD_CLR) begin
        check_eq("clr_cycle", clr_cyc, 1);
        check_eq("clr_count", n_clr, 1);
        check_eq("clr_loads", n_y, 0);
        check_eq("clr_done_cycle", done_cyc, 2);
        check_eq("clr_err", done_err, 0);
      end else if (lat < 0) begin
        check_eq("tmo_loads", n_y, 1);
        check_eq("tmo_starts", n_ma, 1);
        check_eq("tmo_done_cycle", done_cyc, 3 + TMO_CYCLES);
        check_eq("tmo_err", done_err, 1);
      end else begin
        check_eq("loads", n_y, n);
        check_eq("starts", n_ma, n);
        check_eq("clrs", n_clr, 0);
        check_eq("done_cycle", done_cyc, 1 + n * step_len);
        check_eq("done_err", done_err, 0);
      end
      @(negedge clk);
      check_eq("after_done", {bus.done, bus.busy, bus.cmd_ready}, 1);
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.abort = 1'b0; bus.ma_done = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_outputs", {bus.y_op, bus.y_en, bus.y_clr, bus.ma_start, bus.ma_op,
                             bus.done, bus.err, bus.busy, bus.step_idx}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", {bus.cmd_ready, bus.busy}, 2);

    bus.ma_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("idle_ma_done", {bus.busy, bus.step_idx, bus.done}, 0);
    end
    bus.ma_done = 1'b0;

    exec(CMD_CLR, 1, -1, 1'b0, 1'b0);
    exec(CMD_DBL, 1, -1, 1'b0, 1'b0);
    exec(CMD_ADD, -1, -1, 1'b0, 1'b0);
    exec(CMD_LOAD, 1, 0, 1'b0, 1'b0);
    exec(CMD_DBL, 2, -1, 1'b1, 1'b1);

    // Holding ma_done high makes every WAIT one cycle long.
    bus.cmd_valid = 1'b1; bus.cmd_op = CMD_DBL; bus.ma_done = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.y_en && bus.step_idx == 2'd2) found = 1;
      else @(negedge clk);
    end
    check_eq("rst_reach_step2", found, 1);
    rst = 1'b1; bus.ma_done = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_outputs", {bus.y_op, bus.y_en, bus.y_clr, bus.ma_start, bus.ma_op,
                                 bus.done, bus.err, bus.busy, bus.step_idx}, 0);
    model_yop = 0;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_ready", bus.cmd_ready, 1);
    exec(CMD_LOAD, 1, -1, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic [1:0] op;
      int lat, ab;
      op  = 2'($urandom_range(0, 3));
      lat = int'($urandom_range(1, 6));
      ab  = -1;
      if (op != CMD_CLR && $urandom_range(0, 3) == 0)
        ab = int'($urandom_range(0, nsteps[op] - 1));
      exec(op, lat, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
